// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter width; it only has to reach WIDTH_P-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational shift-subtract iteration of the restoring divider.
module div_step #(
    parameter int WIDTH_P = 32
) (
    input  logic [WIDTH_P:0]   p_i,
    input  logic [WIDTH_P-1:0] q_i,
    input  logic [WIDTH_P-1:0] divisor_i,
    output logic [WIDTH_P:0]   p_o,
    output logic [WIDTH_P-1:0] q_o
);

    logic [WIDTH_P:0] shifted;
    logic [WIDTH_P:0] diff;
    logic             ge;

    assign shifted = {p_i[WIDTH_P-1:0], q_i[WIDTH_P-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    // A set top bit would mean the shift overflowed, which always exceeds the divisor.
    assign ge      = p_i[WIDTH_P] | (shifted >= {1'b0, divisor_i});

    always_comb begin
        p_o = shifted;
        q_o = {q_i[WIDTH_P-2:0], 1'b0};
        if (ge) begin
            p_o = diff;
            q_o = {q_i[WIDTH_P-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, done pulse on completion.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH_P = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               start,
    input  logic [WIDTH_P-1:0] dividend,
    input  logic [WIDTH_P-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_P-1:0] quotient,
    output logic [WIDTH_P-1:0] remainder,
    output logic               div_by_zero
);

    localparam int CNT_W = cnt_w(WIDTH_P);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH_P - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH_P:0]   p_q, p_d;
    logic [WIDTH_P-1:0] q_q, q_d;
    logic [WIDTH_P-1:0] dvsr_q;
    logic [WIDTH_P-1:0] quot_q, rem_q;
    logic               busy_q, done_q, dbz_q;

    div_step #(.WIDTH_P(WIDTH_P)) u_step (
        .p_i       (p_q),
        .q_i       (q_q),
        .divisor_i (dvsr_q),
        .p_o       (p_d),
        .q_o       (q_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            // Zero divisor short-circuits straight to a result.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            dbz_q   <= 1'b0;
                            dvsr_q  <= divisor;
                            p_q     <= '0;
                            q_q     <= dividend;
                            cnt_q   <= '0;
                        end
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= p_d[WIDTH_P-1:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
